wb_arbiter2: RTL

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arb_pkg.sv | 18 +
 rtl/wb_if.sv | 23 ++
 rtl/wb_arbiter2.sv | 129 ++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the two-master Wishbone B4 pipelined arbiter.
package wb_arb_pkg;

   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT0 = 2'd1,
      GNT1 = 2'd2
   } arb_state_t;

   // Returns the index of the master to grant; on a tie the one not granted last wins.
   function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
      if (req0 && req1) return ~last;
      return req1;
   endfunction

endpackage

// File: rtl/wb_if.sv
// Wishbone B4 pipelined bus bundle; master drives request side, slave drives response side.
interface wb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_m;
   logic [31:0] dat_s;
   logic        ack;
   logic        err;
   logic        stall;

   modport master (
      output cyc, stb, we, sel, adr, dat_m,
      input  dat_s, ack, err, stall
   );

   modport slave (
      input  cyc, stb, we, sel, adr, dat_m,
      output dat_s, ack, err, stall
   );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone B4 pipelined arbiter with outstanding-request
// limiting and a synthesized error on slave silence.
module wb_arbiter2
   import wb_arb_pkg::*;
#(
   parameter int unsigned MAX_OUTST = 4,
   parameter int unsigned TIMEOUT   = 255
) (
   input  logic clk,
   input  logic rst,
   wb_if.slave  m0,
   wb_if.slave  m1,
   wb_if.master s
);

   localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   arb_state_t       r_state;
   arb_state_t       w_next;
   logic             r_last;
   logic [CNT_W-1:0] r_outst;
   logic [TW-1:0]    r_tmo;

   logic w_gnt;
   logic w_own_cyc;
   logic w_own_stb;
   logic w_full;
   logic w_busy;
   logic w_hit;
   logic w_inc;
   logic w_dec;

   assign w_gnt     = (r_state == GNT0) || (r_state == GNT1);
   assign w_own_cyc = (r_state == GNT0) ? m0.cyc : (r_state == GNT1) ? m1.cyc : 1'b0;
   assign w_own_stb = (r_state == GNT0) ? m0.stb : (r_state == GNT1) ? m1.stb : 1'b0;
   assign w_full    = (r_outst == CNT_W'(MAX_OUTST));
   assign w_busy    = w_gnt && w_own_cyc && (r_outst != '0);

   // r_tmo counts silent cycles already elapsed, so the error fires on the TIMEOUT-th one.
   assign w_hit = w_busy && !s.ack && !s.err && (r_tmo == TW'(TIMEOUT - 1));
   assign w_inc = w_gnt && w_own_stb && !w_full && !s.stall;
   assign w_dec = w_busy && (s.ack || s.err || w_hit);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_last  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE && w_next != IDLE)
            r_last <= (w_next == GNT1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_outst <= '0;
         r_tmo   <= '0;
      end else begin
         if (!w_gnt || !w_own_cyc)
            r_outst <= '0;
         else if (w_inc && !w_dec)
            r_outst <= r_outst + CNT_W'(1);
         else if (w_dec && !w_inc)
            r_outst <= r_outst - CNT_W'(1);

         if (!w_busy || s.ack || s.err || w_hit)
            r_tmo <= '0;
         else
            r_tmo <= r_tmo + TW'(1);
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE: begin
            if (m0.cyc || m1.cyc)
               w_next = rr_pick(m0.cyc, m1.cyc, r_last) ? GNT1 : GNT0;
         end
         GNT0:    if (!m0.cyc) w_next = IDLE;
         GNT1:    if (!m1.cyc) w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_comb begin
      s.cyc    = 1'b0;
      s.stb    = 1'b0;
      s.we     = 1'b0;
      s.sel    = '0;
      s.adr    = '0;
      s.dat_m  = '0;
      m0.stall = 1'b1;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m0.dat_s = s.dat_s;
      m1.stall = 1'b1;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      m1.dat_s = s.dat_s;
      case (r_state)
         GNT0: begin
            s.cyc    = m0.cyc;
            s.stb    = m0.stb && !w_full;
            s.we     = m0.we;
            s.sel    = m0.sel;
            s.adr    = m0.adr;
            s.dat_m  = m0.dat_m;
            m0.stall = s.stall || w_full;
            m0.ack   = s.ack && !s.err;
            m0.err   = s.err || w_hit;
         end
         GNT1: begin
            s.cyc    = m1.cyc;
            s.stb    = m1.stb && !w_full;
            s.we     = m1.we;
            s.sel    = m1.sel;
            s.adr    = m1.adr;
            s.dat_m  = m1.dat_m;
            m1.stall = s.stall || w_full;
            m1.ack   = s.ack && !s.err;
            m1.err   = s.err || w_hit;
         end
         default: ;
      endcase
   end

endmodule
